// File: rtl/command_tag_arbiter.sv
// command_tag_arbiter
//   Round-robin arbiter that issues commands from four requesters, consuming
//   one tag from the tag pool and one PSL command credit per grant.
//   Responses return the credit and release one outstanding command of the
//   owning requester.
//
// Ports
//   clock, rstn              single rising-edge clock, async active-low reset
//   enabled_in               arbiter enable (registered before use)
//   req_valid / req_cmd_in   per-requester request and 64-bit payload
//   req_grant                one-hot grant (combinational)
//   tag_buffer_ready         tag pool non-empty
//   command_tag_in           tag at head of pool
//   room_in                  credit count, sampled in LOAD
//   response_valid/_req_id   one command completed for the given requester
//   tag_command_valid/_id    tag pool pop + tag-RAM write (combinational)
//   cmd_valid/cmd_out/cmd_tag registered issued command
//   outstanding_total        sum of outstanding commands over all requesters
//   arb_error                sticky bad-response flag
//   grant_count_out          per-requester grant counters
//
// Build option
//   ARBITER_GRANT_STATS_EN   when defined, grant_count_out counts grants per
//                            requester (wrapping); otherwise it is tied to 0.
//
// States
//   IDLE  | waiting for registered enable
//   LOAD  | one cycle; credit and loaded room captured from room_in
//   RUN   | grants allowed
//   DRAIN | enable dropped; wait for all outstanding commands to complete

module command_tag_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int PER_REQ_LIMIT  = 64
) (
  input  logic                             clock,
  input  logic                             rstn,
  input  logic                             enabled_in,
  input  logic [NUM_REQUESTERS-1:0]        req_valid,
  input  logic [NUM_REQUESTERS-1:0][63:0]  req_cmd_in,
  output logic [NUM_REQUESTERS-1:0]        req_grant,
  input  logic                             tag_buffer_ready,
  input  logic [7:0]                       command_tag_in,
  input  logic [7:0]                       room_in,
  input  logic                             response_valid,
  input  logic [1:0]                       response_req_id,
  output logic                             tag_command_valid,
  output logic [1:0]                       tag_command_id,
  output logic                             cmd_valid,
  output logic [63:0]                      cmd_out,
  output logic [7:0]                       cmd_tag,
  output logic [8:0]                       outstanding_total,
  output logic                             arb_error,
  output logic [NUM_REQUESTERS-1:0][31:0]  grant_count_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] LIMIT = 8'(PER_REQ_LIMIT);

  state_t                            state_q, state_d;
  logic                              enabled_q;
  logic [1:0]                        ptr_q, ptr_d;
  logic [7:0]                        credit_q, credit_d;
  logic [7:0]                        loaded_room_q, loaded_room_d;
  logic [NUM_REQUESTERS-1:0][7:0]    outstanding_q, outstanding_d;
  logic [8:0]                        total_q, total_d;
  logic                              arb_error_q, arb_error_d;
  logic                              cmd_valid_q, cmd_valid_d;
  logic [63:0]                       cmd_out_q, cmd_out_d;
  logic [7:0]                        cmd_tag_q, cmd_tag_d;

  logic [NUM_REQUESTERS-1:0]         eligible;
  logic                              can_grant;
  logic                              grant_any;
  logic [1:0]                        grant_id;
  logic [1:0]                        idx;
  logic                              resp_ok;
  logic                              resp_err;
  logic                              inc;
  logic                              dec;

  // Grant selection: first eligible requester at or after the pointer.
  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      eligible[i] = req_valid[i] && (outstanding_q[i] < LIMIT);
    end
    can_grant = (state_q == ST_RUN) && (credit_q != 8'd0) && tag_buffer_ready;
    grant_any = 1'b0;
    grant_id  = ptr_q;
    idx       = ptr_q;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_any && can_grant && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    req_grant = '0;
    if (grant_any) req_grant[grant_id] = 1'b1;
  end

  assign tag_command_valid = grant_any;
  assign tag_command_id    = grant_id;

  // A response is only honoured if it has something to release: a non-zero
  // outstanding count for its requester and a credit below the loaded room.
  always_comb begin
    resp_ok  = response_valid && (outstanding_q[response_req_id] != 8'd0)
               && (credit_q != loaded_room_q);
    resp_err = response_valid && !resp_ok;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    loaded_room_d = loaded_room_q;
    outstanding_d = outstanding_q;
    total_d       = total_q;
    arb_error_d   = arb_error_q | resp_err;
    cmd_valid_d   = grant_any;
    cmd_out_d     = cmd_out_q;
    cmd_tag_d     = cmd_tag_q;
    inc           = 1'b0;
    dec           = 1'b0;

    case (state_q)
      ST_IDLE:  if (enabled_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN:   if (!enabled_q) state_d = ST_DRAIN;
      ST_DRAIN: if (total_q == 9'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (grant_any) begin
      ptr_d     = grant_id + 2'd1;
      cmd_out_d = req_cmd_in[grant_id];
      cmd_tag_d = command_tag_in;
    end

    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      inc = grant_any && (grant_id == 2'(i));
      dec = resp_ok && (response_req_id == 2'(i));
      if (inc && !dec)      outstanding_d[i] = outstanding_q[i] + 8'd1;
      else if (dec && !inc) outstanding_d[i] = outstanding_q[i] - 8'd1;
    end

    if (grant_any && !resp_ok)      total_d = total_q + 9'd1;
    else if (resp_ok && !grant_any) total_d = total_q - 9'd1;

    // LOAD overrides credit arithmetic; no grants can occur in LOAD anyway.
    if (state_q == ST_LOAD) begin
      credit_d      = room_in;
      loaded_room_d = room_in;
    end else if (grant_any && !resp_ok) begin
      credit_d = credit_q - 8'd1;
    end else if (resp_ok && !grant_any) begin
      credit_d = credit_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      enabled_q     <= 1'b0;
      ptr_q         <= 2'd0;
      credit_q      <= 8'd0;
      loaded_room_q <= 8'd0;
      outstanding_q <= '0;
      total_q       <= 9'd0;
      arb_error_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_out_q     <= 64'd0;
      cmd_tag_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      enabled_q     <= enabled_in;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      loaded_room_q <= loaded_room_d;
      outstanding_q <= outstanding_d;
      total_q       <= total_d;
      arb_error_q   <= arb_error_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_out_q     <= cmd_out_d;
      cmd_tag_q     <= cmd_tag_d;
    end
  end

  assign cmd_valid         = cmd_valid_q;
  assign cmd_out           = cmd_out_q;
  assign cmd_tag           = cmd_tag_q;
  assign outstanding_total = total_q;
  assign arb_error         = arb_error_q;

`ifdef ARBITER_GRANT_STATS_EN
  logic [NUM_REQUESTERS-1:0][31:0] grant_count_q, grant_count_d;

  always_comb begin
    grant_count_d = grant_count_q;
    if (grant_any) grant_count_d[grant_id] = grant_count_q[grant_id] + 32'd1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) grant_count_q <= '0;
    else       grant_count_q <= grant_count_d;
  end

  assign grant_count_out = grant_count_q;
`else
  assign grant_count_out = '0;
`endif

endmodule

// File: tb/tb_command_tag_arbiter.sv
module tb_command_tag_arbiter;

  localparam int LIMIT = 64;

  logic             clock;
  logic             rstn;
  logic             enabled_in;
  logic [3:0]       req_valid;
  logic [3:0][63:0] req_cmd_in;
  logic [3:0]       req_grant;
  logic             tag_buffer_ready;
  logic [7:0]       command_tag_in;
  logic [7:0]       room_in;
  logic             response_valid;
  logic [1:0]       response_req_id;
  logic             tag_command_valid;
  logic [1:0]       tag_command_id;
  logic             cmd_valid;
  logic [63:0]      cmd_out;
  logic [7:0]       cmd_tag;
  logic [8:0]       outstanding_total;
  logic             arb_error;
  logic [3:0][31:0] grant_count_out;

  command_tag_arbiter #(.NUM_REQUESTERS(4), .PER_REQ_LIMIT(LIMIT)) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .req_valid(req_valid), .req_cmd_in(req_cmd_in), .req_grant(req_grant),
    .tag_buffer_ready(tag_buffer_ready), .command_tag_in(command_tag_in),
    .room_in(room_in), .response_valid(response_valid),
    .response_req_id(response_req_id), .tag_command_valid(tag_command_valid),
    .tag_command_id(tag_command_id), .cmd_valid(cmd_valid), .cmd_out(cmd_out),
    .cmd_tag(cmd_tag), .outstanding_total(outstanding_total),
    .arb_error(arb_error), .grant_count_out(grant_count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int gq[$];   // observed grant ids, in order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DRAIN = 3;
  int          m_phase, m_credit, m_room, m_ptr;
  int          m_out[4];
  bit          m_err, m_en, m_cv;
  logic [63:0] m_cmd;
  logic [7:0]  m_tag;
  logic [31:0] m_gcnt[4];

  task automatic model_reset();
    m_phase = P_IDLE; m_credit = 0; m_room = 0; m_ptr = 0;
    m_err = 0; m_en = 0; m_cv = 0; m_cmd = '0; m_tag = '0;
    for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_gcnt[i] = '0; end
  endtask

  // Inputs change at the falling edge; outputs are compared 3 time units
  // later, then the model advances to what the next rising edge produces.
  always @(negedge clock) begin
    int          sum, eg_id, cand;
    bit          eg_any, rok;
    logic [3:0]  eg;
    #3;
    if (!rstn) begin
      model_reset();
      chk("rst_grant", {60'd0, req_grant}, 64'd0);
      chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
      chk("rst_cmd_out", cmd_out, 64'd0);
      chk("rst_cmd_tag", {56'd0, cmd_tag}, 64'd0);
      chk("rst_total", {55'd0, outstanding_total}, 64'd0);
      chk("rst_err", {63'd0, arb_error}, 64'd0);
    end else begin
      sum = 0;
      for (int i = 0; i < 4; i++) sum += m_out[i];
      eg_any = 0; eg_id = 0; eg = '0;
      if (m_phase == P_RUN && m_credit > 0 && tag_buffer_ready) begin
        for (int k = 0; k < 4; k++) begin
          cand = (m_ptr + k) % 4;
          if (!eg_any && req_valid[cand] && m_out[cand] < LIMIT) begin
            eg_any = 1; eg_id = cand;
          end
        end
      end
      if (eg_any) eg[eg_id] = 1'b1;

      chk("req_grant", {60'd0, req_grant}, {60'd0, eg});
      chk("tag_cmd_valid", {63'd0, tag_command_valid}, {63'd0, eg_any});
      if (eg_any) chk("tag_cmd_id", {62'd0, tag_command_id}, 64'(eg_id));
      chk("cmd_valid", {63'd0, cmd_valid}, {63'd0, m_cv});
      if (m_cv) begin
        chk("cmd_out", cmd_out, m_cmd);
        chk("cmd_tag", {56'd0, cmd_tag}, {56'd0, m_tag});
      end
      chk("outstanding_total", {55'd0, outstanding_total}, 64'(sum));
      chk("arb_error", {63'd0, arb_error}, {63'd0, m_err});
      for (int i = 0; i < 4; i++) begin
`ifdef ARBITER_GRANT_STATS_EN
        chk("grant_count", {32'd0, grant_count_out[i]}, {32'd0, m_gcnt[i]});
`else
        chk("grant_count", {32'd0, grant_count_out[i]}, 64'd0);
`endif
      end
      if (tag_command_valid) gq.push_back(int'(tag_command_id));

      // advance model
      rok = response_valid && m_out[response_req_id] > 0 && m_credit != m_room;
      if (response_valid && !rok) m_err = 1;
      if (eg_any) begin
        m_out[eg_id]++;
        m_gcnt[eg_id] = m_gcnt[eg_id] + 32'd1;
        m_ptr = (eg_id + 1) % 4;
        m_cmd = req_cmd_in[eg_id];
        m_tag = command_tag_in;
      end
      m_cv = eg_any;
      if (rok) m_out[response_req_id]--;
      if (m_phase == P_LOAD) begin
        m_credit = int'(room_in); m_room = int'(room_in);
      end else begin
        m_credit = m_credit - int'(eg_any) + int'(rok);
      end
      case (m_phase)
        P_IDLE:  if (m_en) m_phase = P_LOAD;
        P_LOAD:  m_phase = P_RUN;
        P_RUN:   if (!m_en) m_phase = P_DRAIN;
        default: if (sum == 0) m_phase = P_IDLE;
      endcase
      m_en = enabled_in;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(negedge clock); endtask

  task automatic do_reset();
    rstn = 1'b0; enabled_in = 0; req_valid = '0; tag_buffer_ready = 0;
    command_tag_in = '0; room_in = '0; response_valid = 0; response_req_id = '0;
    for (int i = 0; i < 4; i++) req_cmd_in[i] = {8'(i), 48'h0, 8'hEE};
    tick(); tick();
    rstn = 1'b1;
    gq.delete();
  endtask

  initial begin
    int budget;
    rstn = 1'b0;
    do_reset();
    chk("lit_rst_total", {55'd0, outstanding_total}, 64'd0);
    chk("lit_rst_grant", {60'd0, req_grant}, 64'd0);

    // all four requesting, 16 credits: rotating grants, then stall
    enabled_in = 1; room_in = 8'd16; req_valid = 4'hF; tag_buffer_ready = 1;
    for (int t = 0; t < 30; t++) begin
      command_tag_in = 8'(t + 8'h40);
      for (int i = 0; i < 4; i++) req_cmd_in[i] = {8'(i), 48'h0, 8'(t)};
      tick();
    end
    chk("lit_rr_count", 64'(gq.size()), 64'd16);
    for (int i = 0; i < 16 && i < gq.size(); i++)
      chk("lit_rr_order", 64'(gq[i]), 64'(i % 4));
    chk("lit_rr_total", {55'd0, outstanding_total}, 64'd16);

    // tags unavailable: a freed credit must not produce a grant
    tag_buffer_ready = 0; response_valid = 1; response_req_id = 2'd2;
    tick();
    response_valid = 0;
    repeat (4) tick();
    chk("lit_notag_count", 64'(gq.size()), 64'd16);
    tag_buffer_ready = 1;
    tick();
    chk("lit_tagback_count", 64'(gq.size()), 64'd17);
    if (gq.size() > 16) chk("lit_tagback_id", 64'(gq[16]), 64'd0);

    // only requester 2: capped at the per-requester limit
    do_reset();
    enabled_in = 1; room_in = 8'd200; req_valid = 4'b0100; tag_buffer_ready = 1;
    repeat (80) tick();
    chk("lit_limit_count", 64'(gq.size()), 64'd64);
    if (gq.size() > 0) chk("lit_limit_id", 64'(gq[gq.size()-1]), 64'd2);
    chk("lit_limit_total", {55'd0, outstanding_total}, 64'd64);
    chk("lit_limit_grant", {60'd0, req_grant}, 64'd0);

    // three grants to requester 1 (credit 8 -> 5), then grant+response together
    do_reset();
    enabled_in = 1; room_in = 8'd8; req_valid = 4'b0010; tag_buffer_ready = 1;
    budget = 20;
    while (gq.size() < 3 && budget > 0) begin tick(); budget--; end
    req_valid = '0;
    tick();
    chk("lit_three_grants", 64'(gq.size()), 64'd3);
    req_valid = 4'b0010; response_valid = 1; response_req_id = 2'd1;
    tick();
    req_valid = '0; response_valid = 0;
    tick();
    chk("lit_same_count", 64'(gq.size()), 64'd4);
    if (gq.size() > 3) chk("lit_same_id", 64'(gq[3]), 64'd1);
    chk("lit_same_total", {55'd0, outstanding_total}, 64'd3);
    chk("lit_same_err", {63'd0, arb_error}, 64'd0);

    // response for an idle requester flags an error and changes nothing
    response_valid = 1; response_req_id = 2'd3;
    tick();
    response_valid = 0;
    tick();
    chk("lit_bad_err", {63'd0, arb_error}, 64'd1);
    chk("lit_bad_total", {55'd0, outstanding_total}, 64'd3);

    // drop enable: drain with requests held, no grants
    enabled_in = 0;
    repeat (3) tick();
    req_valid = 4'b0010;
    repeat (5) tick();
    chk("lit_drain_nogrant", 64'(gq.size()), 64'd4);
    response_valid = 1; response_req_id = 2'd1;
    repeat (3) tick();
    response_valid = 0;
    repeat (3) tick();
    chk("lit_drain_total", {55'd0, outstanding_total}, 64'd0);
    chk("lit_drain_err", {63'd0, arb_error}, 64'd1);
    chk("lit_idle_nogrant", 64'(gq.size()), 64'd4);

    // re-enable: the held request is served
    enabled_in = 1;
    budget = 10;
    while (gq.size() < 5 && budget > 0) begin tick(); budget--; end
    chk("lit_reen_count", 64'(gq.size()), 64'd5);
    if (gq.size() > 4) chk("lit_reen_id", 64'(gq[4]), 64'd1);
    req_valid = '0;
    repeat (3) tick();
    chk("lit_reen_total", {55'd0, outstanding_total}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
